// File: rtl/operand_stage.sv
// operand_stage: resolves the two execute operands for one instruction.
// Register sources come from the register file or the forwarding channels
// (channel 0 is youngest and wins). A used source whose forwarding channel is
// still pending parks the instruction in WAIT until the data arrives.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   flush                   discard whatever the stage holds
//   in_valid/in_ready       decode handshake
//   in_pc, in_rs1/2, in_rd1/2, in_imm, in_a_sel, in_b_sel, in_shmode
//                           instruction fields and register-file read data
//   fwd_valid/rd/pending/data
//                           forwarding channels, packed NUM_FWD-wide
//   out_valid/out_ready     execute handshake
//   out_srca, out_srcb      resolved operands
//   stall_cnt               saturating count of cycles spent in WAIT
module operand_stage #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned NUM_FWD = 3,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [XLEN-1:0]         in_pc,
   input  logic [4:0]              in_rs1,
   input  logic [4:0]              in_rs2,
   input  logic [XLEN-1:0]         in_rd1,
   input  logic [XLEN-1:0]         in_rd2,
   input  logic [XLEN-1:0]         in_imm,
   input  logic [1:0]              in_a_sel,
   input  logic [1:0]              in_b_sel,
   input  logic [1:0]              in_shmode,
   input  logic [NUM_FWD-1:0]      fwd_valid,
   input  logic [NUM_FWD*5-1:0]    fwd_rd,
   input  logic [NUM_FWD-1:0]      fwd_pending,
   input  logic [NUM_FWD*XLEN-1:0] fwd_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         out_srca,
   output logic [XLEN-1:0]         out_srcb,
   output logic [CNT_W-1:0]        stall_cnt
);

   localparam logic [1:0] A_RS1 = 2'd0;
   localparam logic [1:0] A_PC  = 2'd1;
   localparam logic [1:0] A_IMM = 2'd2;
   localparam logic [1:0] B_RS2 = 2'd0;
   localparam logic [1:0] B_IMM = 2'd1;
   localparam logic [1:0] B_C4  = 2'd2;

   typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;

   state_t            state;
   logic [XLEN-1:0]   cap_pc, cap_imm, cap_a, cap_b;
   logic [4:0]        cap_rs1, cap_rs2;
   logic [1:0]        cap_a_sel, cap_b_sel, cap_shmode;
   logic              cap_a_ok, cap_b_ok;

   logic              waiting, accept, all_ok, ok_a, ok_b;
   logic [XLEN-1:0]   cur_pc, cur_imm, cur_rd1, cur_rd2, val_a, val_b, nxt_a, nxt_b;
   logic [4:0]        cur_rs1, cur_rs2;
   logic [1:0]        cur_a_sel, cur_b_sel, cur_shmode;
   logic [XLEN:0]     res_a, res_b;

   // Returns {resolved, value}; lowest-index matching channel wins, x0 is always zero.
   function automatic logic [XLEN:0] resolve_reg(
      input logic [4:0]              idx,
      input logic [XLEN-1:0]         fallback,
      input logic [NUM_FWD-1:0]      valid,
      input logic [NUM_FWD-1:0]      pend,
      input logic [NUM_FWD*5-1:0]    rd,
      input logic [NUM_FWD*XLEN-1:0] data
   );
      logic            found;
      logic            ok;
      logic [XLEN-1:0] val;
      found = 1'b0;
      ok    = 1'b1;
      val   = fallback;
      if (idx == 5'd0) begin
         val = '0;
      end else begin
         for (int i = 0; i < int'(NUM_FWD); i++) begin
            if (!found && valid[i] && (rd[i*5 +: 5] == idx)) begin
               found = 1'b1;
               ok    = !pend[i];
               val   = data[i*XLEN +: XLEN];
            end
         end
      end
      return {ok, val};
   endfunction

   // Operand multiplexing followed by shift-amount masking of srcb.
   function automatic logic [2*XLEN-1:0] build_ops(
      input logic [1:0]      a_sel,
      input logic [1:0]      b_sel,
      input logic [1:0]      shmode,
      input logic [XLEN-1:0] pc,
      input logic [XLEN-1:0] imm,
      input logic [XLEN-1:0] ra,
      input logic [XLEN-1:0] rb
   );
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      case (a_sel)
         A_RS1:   a = ra;
         A_PC:    a = pc;
         A_IMM:   a = imm;
         default: a = '0;
      endcase
      case (b_sel)
         B_RS2:   b = rb;
         B_IMM:   b = imm;
         B_C4:    b = XLEN'(4);
         default: b = '0;
      endcase
      if (shmode == 2'd1)      b = b & XLEN'(6'h3f);
      else if (shmode == 2'd2) b = b & XLEN'(5'h1f);
      return {a, b};
   endfunction

   assign in_ready = !reset && !flush && ((state == IDLE) || ((state == FULL) && out_ready));
   assign accept   = in_valid && in_ready;
   assign waiting  = (state == WAIT);

   // In WAIT the captured instruction is re-resolved; otherwise the incoming one.
   always_comb begin
      cur_pc     = waiting ? cap_pc     : in_pc;
      cur_imm    = waiting ? cap_imm    : in_imm;
      cur_rs1    = waiting ? cap_rs1    : in_rs1;
      cur_rs2    = waiting ? cap_rs2    : in_rs2;
      cur_rd1    = waiting ? cap_a      : in_rd1;
      cur_rd2    = waiting ? cap_b      : in_rd2;
      cur_a_sel  = waiting ? cap_a_sel  : in_a_sel;
      cur_b_sel  = waiting ? cap_b_sel  : in_b_sel;
      cur_shmode = waiting ? cap_shmode : in_shmode;

      res_a = resolve_reg(cur_rs1, cur_rd1, fwd_valid, fwd_pending, fwd_rd, fwd_data);
      res_b = resolve_reg(cur_rs2, cur_rd2, fwd_valid, fwd_pending, fwd_rd, fwd_data);

      // Already-resolved operands keep their captured value; unresolved ones keep rd data.
      if (waiting && cap_a_ok) val_a = cap_a;
      else                     val_a = res_a[XLEN] ? res_a[XLEN-1:0] : cur_rd1;
      if (waiting && cap_b_ok) val_b = cap_b;
      else                     val_b = res_b[XLEN] ? res_b[XLEN-1:0] : cur_rd2;

      ok_a   = (cur_a_sel != A_RS1) || (waiting && cap_a_ok) || res_a[XLEN];
      ok_b   = (cur_b_sel != B_RS2) || (waiting && cap_b_ok) || res_b[XLEN];
      all_ok = ok_a && ok_b;

      {nxt_a, nxt_b} = build_ops(cur_a_sel, cur_b_sel, cur_shmode, cur_pc, cur_imm, val_a, val_b);
   end

   // Stage FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         out_srca   <= '0;
         out_srcb   <= '0;
         stall_cnt  <= '0;
         cap_pc     <= '0;
         cap_imm    <= '0;
         cap_a      <= '0;
         cap_b      <= '0;
         cap_rs1    <= '0;
         cap_rs2    <= '0;
         cap_a_sel  <= '0;
         cap_b_sel  <= '0;
         cap_shmode <= '0;
         cap_a_ok   <= 1'b0;
         cap_b_ok   <= 1'b0;
      end else begin
         if (waiting && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);

         if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
         end else if (accept || waiting) begin
            if (accept) begin
               cap_pc     <= in_pc;
               cap_imm    <= in_imm;
               cap_rs1    <= in_rs1;
               cap_rs2    <= in_rs2;
               cap_a_sel  <= in_a_sel;
               cap_b_sel  <= in_b_sel;
               cap_shmode <= in_shmode;
            end
            cap_a    <= val_a;
            cap_b    <= val_b;
            cap_a_ok <= ok_a;
            cap_b_ok <= ok_b;
            if (all_ok) begin
               state     <= FULL;
               out_valid <= 1'b1;
               out_srca  <= nxt_a;
               out_srcb  <= nxt_b;
            end else begin
               state     <= WAIT;
               out_valid <= 1'b0;
            end
         end else if ((state == FULL) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: vector table, directed multi-cycle sequences and random
// traffic for operand_stage, all checked against a cycle-level reference model.
module tb_operand_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [63:0]       in_pc, in_rd1, in_rd2, in_imm, out_srca, out_srcb;
   logic [4:0]        in_rs1, in_rs2;
   logic [1:0]        in_a_sel, in_b_sel, in_shmode;
   logic [2:0]        fwd_valid, fwd_pending;
   logic [2:0][4:0]   t_frd;
   logic [2:0][63:0]  t_fd;
   logic [14:0]       fwd_rd;
   logic [191:0]      fwd_data;
   logic [15:0]       stall_cnt;

   assign fwd_rd   = t_frd;
   assign fwd_data = t_fd;

   operand_stage dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
      .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_shmode(in_shmode),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_pending(fwd_pending), .fwd_data(fwd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_srca(out_srca), .out_srcb(out_srcb), .stall_cnt(stall_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_wait, m_full, h_aok, h_bok;
   int          m_stall;
   logic [63:0] m_a, m_b, h_pc, h_imm, h_ra, h_rb;
   logic [4:0]  h_rs1, h_rs2;
   logic [1:0]  h_as, h_bs, h_sh;

   function automatic void ref_lookup(input logic [4:0] idx, input logic [63:0] rf,
                                      output bit ok, output logic [63:0] v);
      ok = 1'b1;
      v  = rf;
      if (idx == 5'd0) begin
         v = '0;
         return;
      end
      for (int i = 0; i < 3; i++) begin
         if (fwd_valid[i] && t_frd[i] == idx) begin
            ok = !fwd_pending[i];
            if (ok) v = t_fd[i];
            return;
         end
      end
   endfunction

   function automatic void ref_settle();
      if (h_aok && h_bok) begin
         m_wait = 1'b0;
         m_full = 1'b1;
         case (h_as)
            2'd0: m_a = h_ra;
            2'd1: m_a = h_pc;
            2'd2: m_a = h_imm;
            default: m_a = 64'd0;
         endcase
         case (h_bs)
            2'd0: m_b = h_rb;
            2'd1: m_b = h_imm;
            2'd2: m_b = 64'd4;
            default: m_b = 64'd0;
         endcase
         if (h_sh == 2'd1)      m_b = m_b % 64;
         else if (h_sh == 2'd2) m_b = m_b % 32;
      end else begin
         m_wait = 1'b1;
         m_full = 1'b0;
      end
   endfunction

   // One clock: check in_ready before the edge, advance the model, check outputs after.
   task automatic step();
      bit exp_ready, acc;
      #1;
      exp_ready = !reset && !flush && !m_wait && (!m_full || out_ready);
      chk("model_in_ready", in_ready, exp_ready);
      acc = in_valid && exp_ready;
      @(posedge clk);
      if (reset) begin
         m_wait = 0; m_full = 0; m_stall = 0; m_a = 0; m_b = 0;
      end else begin
         if (m_wait && m_stall < 65535) m_stall++;
         if (flush) begin
            m_wait = 0; m_full = 0;
         end else if (acc) begin
            h_pc = in_pc; h_imm = in_imm; h_rs1 = in_rs1; h_rs2 = in_rs2;
            h_as = in_a_sel; h_bs = in_b_sel; h_sh = in_shmode;
            h_ra = in_rd1; h_rb = in_rd2; h_aok = 1; h_bok = 1;
            if (h_as == 2'd0) ref_lookup(h_rs1, in_rd1, h_aok, h_ra);
            if (h_bs == 2'd0) ref_lookup(h_rs2, in_rd2, h_bok, h_rb);
            ref_settle();
         end else if (m_wait) begin
            if (!h_aok) ref_lookup(h_rs1, h_ra, h_aok, h_ra);
            if (!h_bok) ref_lookup(h_rs2, h_rb, h_bok, h_rb);
            ref_settle();
         end else if (m_full && out_ready) begin
            m_full = 0;
         end
      end
      #1;
      chk("model_out_valid", out_valid, m_full);
      chk("model_srca", out_srca, m_a);
      chk("model_srcb", out_srcb, m_b);
      chk("model_stall_cnt", stall_cnt, 64'(m_stall));
   endtask

   task automatic clr_in();
      flush = 0; in_valid = 0; out_ready = 0;
      in_pc = 0; in_rd1 = 0; in_rd2 = 0; in_imm = 0; in_rs1 = 0; in_rs2 = 0;
      in_a_sel = 0; in_b_sel = 0; in_shmode = 0;
      fwd_valid = 0; fwd_pending = 0; t_frd = '0; t_fd = '0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0]       asel, bsel, sh;
      logic [4:0]       rs1, rs2;
      logic [63:0]      rd1, rd2, pc, imm;
      logic [2:0]       fv, fp;
      logic [2:0][4:0]  frd;
      logic [2:0][63:0] fd;
      logic [63:0]      ea, eb;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] asel, bsel, sh, input logic [4:0] rs1, rs2,
                               input logic [63:0] rd1, rd2, pc, imm,
                               input logic [2:0] fv, fp, input logic [4:0] r0, r1, r2,
                               input logic [63:0] d0, d1, d2, ea, eb);
      vec_t v;
      v.asel = asel; v.bsel = bsel; v.sh = sh; v.rs1 = rs1; v.rs2 = rs2;
      v.rd1 = rd1; v.rd2 = rd2; v.pc = pc; v.imm = imm; v.fv = fv; v.fp = fp;
      v.frd[0] = r0; v.frd[1] = r1; v.frd[2] = r2;
      v.fd[0] = d0; v.fd[1] = d1; v.fd[2] = d2; v.ea = ea; v.eb = eb;
      return v;
   endfunction

   vec_t vt[9];

   initial begin
      logic [63:0] pc;
      // asel bsel sh rs1 rs2 rd1 rd2 pc imm fv fp frd0..2 fd0..2 exp_a exp_b
      vt[0] = mk(0, 1, 0, 5, 0, 64'h10, 0, 0, 3, 3'b000, 0, 0, 0, 0, 0, 0, 0, 64'h10, 64'h3);
      vt[1] = mk(0, 3, 0, 7, 0, 64'h1, 0, 0, 0, 3'b101, 0, 7, 0, 7, 64'hAA, 0, 64'hBB, 64'hAA, 0);
      vt[2] = mk(0, 3, 0, 0, 0, 64'h999, 0, 0, 0, 3'b001, 0, 0, 0, 0, 64'h123, 0, 0, 0, 0);
      vt[3] = mk(3, 0, 2, 0, 4, 0, 64'hFFFF_FFFF_FFFF_FFE7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h7);
      vt[4] = mk(3, 0, 1, 0, 4, 0, 64'hFFFF_FFFF_FFFF_FFE7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h27);
      vt[5] = mk(1, 2, 0, 0, 0, 0, 0, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h8000_0000, 64'h4);
      vt[6] = mk(2, 0, 0, 0, 9, 0, 64'h11, 0, 5, 3'b010, 0, 9, 9, 0, 64'h66, 64'h77, 0, 64'h5, 64'h77);
      vt[7] = mk(0, 1, 1, 3, 0, 64'h42, 0, 0, 64'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 64'h42, 64'h34);
      vt[8] = mk(2, 1, 0, 6, 6, 0, 0, 0, 64'h9, 3'b001, 3'b001, 6, 0, 0, 0, 0, 0, 64'h9, 64'h9);

      m_wait = 0; m_full = 0; m_stall = 0; m_a = 0; m_b = 0;
      h_aok = 0; h_bok = 0; h_pc = 0; h_imm = 0; h_ra = 0; h_rb = 0;
      h_rs1 = 0; h_rs2 = 0; h_as = 0; h_bs = 0; h_sh = 0;

      // Reset
      clr_in();
      reset = 1;
      step();
      step();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_srca", out_srca, 0);
      chk("reset_stall", stall_cnt, 0);
      reset = 0;
      #1;
      chk("ready_after_reset", in_ready, 1);

      // Single-instruction vectors, each drained afterwards
      for (int i = 0; i < 9; i++) begin
         in_a_sel = vt[i].asel; in_b_sel = vt[i].bsel; in_shmode = vt[i].sh;
         in_rs1 = vt[i].rs1; in_rs2 = vt[i].rs2; in_rd1 = vt[i].rd1; in_rd2 = vt[i].rd2;
         in_pc = vt[i].pc; in_imm = vt[i].imm;
         fwd_valid = vt[i].fv; fwd_pending = vt[i].fp; t_frd = vt[i].frd; t_fd = vt[i].fd;
         in_valid = 1; out_ready = 0;
         step();
         chk($sformatf("vec%0d_valid", i), out_valid, 1);
         chk($sformatf("vec%0d_srca", i), out_srca, vt[i].ea);
         chk($sformatf("vec%0d_srcb", i), out_srcb, vt[i].eb);
         clr_in();
         out_ready = 1;
         step();
         chk($sformatf("vec%0d_drain", i), out_valid, 0);
      end

      // Load-use: channel 1 pending for three edges, then data arrives
      clr_in();
      in_a_sel = 3; in_b_sel = 0; in_rs2 = 9; in_rd2 = 64'h1; in_valid = 1;
      fwd_valid = 3'b010; fwd_pending = 3'b010; t_frd[1] = 9; t_fd[1] = 64'hdead;
      step();
      in_valid = 0;
      chk("lu_ready_wait0", in_ready, 0);
      step();
      chk("lu_ready_wait1", in_ready, 0);
      step();
      chk("lu_ready_wait2", in_ready, 0);
      chk("lu_not_valid_yet", out_valid, 0);
      fwd_pending = 3'b000; t_fd[1] = 64'h55;
      step();
      chk("lu_valid", out_valid, 1);
      chk("lu_srcb", out_srcb, 64'h55);
      chk("lu_stall", stall_cnt, 3);
      clr_in();
      out_ready = 1;
      step();

      // Backpressure: outputs held for four cycles
      clr_in();
      in_a_sel = 0; in_b_sel = 1; in_rs1 = 5; in_rd1 = 64'habc; in_imm = 3; in_valid = 1;
      step();
      clr_in();
      for (int k = 0; k < 4; k++) begin
         step();
         chk("bp_valid", out_valid, 1);
         chk("bp_srca", out_srca, 64'habc);
         chk("bp_srcb", out_srcb, 64'h3);
      end
      out_ready = 1;
      step();

      // Flush while waiting
      clr_in();
      in_a_sel = 0; in_b_sel = 1; in_rs1 = 4; in_valid = 1;
      fwd_valid = 3'b001; fwd_pending = 3'b001; t_frd[0] = 4;
      step();
      in_valid = 0; flush = 1;
      step();
      flush = 0;
      #1;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      chk("flush_stall", stall_cnt, 4);
      clr_in();

      // JAL-like back-to-back
      in_a_sel = 1; in_b_sel = 2; in_valid = 1; out_ready = 1;
      for (int k = 0; k < 6; k++) begin
         pc = 64'h8000_0000 + 64'(k * 4);
         in_pc = pc;
         step();
         chk("jal_valid", out_valid, 1);
         chk("jal_srca", out_srca, pc);
         chk("jal_srcb", out_srcb, 64'h4);
      end
      clr_in();
      out_ready = 1;
      step();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 199) == 0);
         flush     = ($urandom_range(0, 31) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_pc     = {$urandom, $urandom};
         in_imm    = {$urandom, $urandom};
         in_rd1    = {$urandom, $urandom};
         in_rd2    = {$urandom, $urandom};
         in_rs1    = 5'($urandom_range(0, 3));
         in_rs2    = 5'($urandom_range(0, 3));
         in_a_sel  = 2'($urandom_range(0, 3));
         in_b_sel  = 2'($urandom_range(0, 3));
         in_shmode = 2'($urandom_range(0, 3));
         for (int c = 0; c < 3; c++) begin
            fwd_valid[c]   = ($urandom_range(0, 1) == 1);
            fwd_pending[c] = ($urandom_range(0, 9) < 3);
            t_frd[c]       = 5'($urandom_range(0, 3));
            t_fd[c]        = {$urandom, $urandom};
         end
         step();
      end
      reset = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
